fifo_write_arbiter: RTL and testbench

- Shares the single write port of a FIFO controller among NUM_REQ requesters, each using a valid/ready handshake.
- Selection is round-robin with bounded bursts: a granted requester keeps the port until it sends its last beat, reaches MAX_BURST beats, or drops valid.
- Sits between the producer blocks and the FIFO's data_in/we/full pins.
- Honours FIFO backpressure (full) without losing or duplicating data.

---
 rtl/fifo_write_arbiter_pkg.sv | 29 ++
 rtl/fifo_write_arbiter_pick.sv | 45 ++++
 rtl/fifo_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter_pkg
//
// Shared definitions for the FIFO write-port arbiter and the FIFO controller:
// default data/id widths, the maximum burst length, the arbiter FSM state
// encoding, and a modulo-N increment helper used for round-robin pointers.
// ----------------------------------------------------------------------------
package fifo_write_arbiter_pkg;

    // Defaults shared with the FIFO controller.
    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefIdWidth   = 2;
    localparam int unsigned DefMaxBurst  = 4;

    // Burst counter width; holds MAX_BURST values up to 15.
    localparam int unsigned BurstCntWidth = 4;

    // Arbiter FSM encoding.
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t StIdle  = 1'b0;
    localparam arb_state_t StGrant = 1'b1;

    // Increment modulo n; correct for n that is not a power of two.
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
//
// Purely combinational round-robin search. Starting at start_ptr and walking
// upward modulo NUM_REQ, returns the first index whose req bit is set and
// whose excl_mask bit is clear.
//
// Ports:
//   req        in   NUM_REQ   request vector
//   start_ptr  in   ID_WIDTH  index examined first
//   excl_mask  in   NUM_REQ   indices removed from the search
//   found      out  1         some eligible index exists
//   idx        out  ID_WIDTH  winning index (0 when found=0)
// ----------------------------------------------------------------------------
module rr_priority_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned ID_WIDTH = DefIdWidth
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] start_ptr,
    input  logic [NUM_REQ-1:0]  excl_mask,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    logic [NUM_REQ-1:0] eligible;
    assign eligible = req & ~excl_mask;

    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = start_ptr;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = ID_WIDTH'(wrap_inc(32'(cand), NUM_REQ));
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares one FIFO write port among NUM_REQ valid/ready requesters. Round-robin
// selection; the owner keeps the port until it sends a last beat, reaches
// MAX_BURST beats, or drops valid. FIFO full stalls the owner without release.
//
// Build option: define ARB_B2B_GRANT_EN to hand the port directly to the next
// valid requester on release (no IDLE cycle between grants).
//
// Ports:
//   clk        in   1                   clock, rising edge
//   rst_n      in   1                   asynchronous active-low reset
//   req_valid  in   NUM_REQ             per-requester beat valid
//   req_data   in   NUM_REQ*DATA_WIDTH  packed beats, requester i at i*DATA_WIDTH
//   req_last   in   NUM_REQ             final beat of a burst
//   req_ready  out  NUM_REQ             beat accepted (one-hot or zero)
//   fifo_full  in   1                   FIFO full flag
//   fifo_we    out  1                   FIFO write enable
//   fifo_data  out  DATA_WIDTH          FIFO write data
//   grant_id   out  ID_WIDTH            current owner, valid while busy
//   busy       out  1                   a requester owns the port
// ----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned MAX_BURST  = DefMaxBurst,
    parameter int unsigned ID_WIDTH   = DefIdWidth
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    arb_state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]      grant_id_q, grant_id_d;
    logic [BurstCntWidth-1:0] burst_cnt_q, burst_cnt_d;

    logic                     in_grant;
    logic [NUM_REQ-1:0]       owner_onehot;
    logic                     owner_valid;
    logic                     owner_last;
    logic [DATA_WIDTH-1:0]    owner_data;
    logic                     xfer;
    logic                     release_grant;
    logic [BurstCntWidth-1:0] burst_cnt_inc;
    logic [ID_WIDTH-1:0]      next_ptr;
    logic                     idle_found;
    logic [ID_WIDTH-1:0]      idle_idx;

    assign in_grant = (state_q == StGrant);

    // Owner mux built from constant slices to keep the data select simple.
    always_comb begin
        owner_onehot = '0;
        owner_data   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_WIDTH'(i)) begin
                owner_onehot[i] = 1'b1;
                owner_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_valid = |(req_valid & owner_onehot);
    assign owner_last  = |(req_last & owner_onehot);

    assign req_ready = (in_grant && !fifo_full) ? owner_onehot : '0;
    assign xfer      = in_grant && owner_valid && !fifo_full;
    assign fifo_we   = xfer;
    assign fifo_data = owner_data;

    assign burst_cnt_inc = burst_cnt_q + 1'b1;

    // Full alone never releases; a valid drop releases even while full.
    assign release_grant = in_grant &&
        ((xfer && (owner_last || burst_cnt_inc == BurstCntWidth'(MAX_BURST))) || !owner_valid);

    assign next_ptr = ID_WIDTH'(wrap_inc(32'(grant_id_q), NUM_REQ));

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_idle_pick (
        .req       (req_valid),
        .start_ptr (rr_ptr_q),
        .excl_mask ({NUM_REQ{1'b0}}),
        .found     (idle_found),
        .idx       (idle_idx)
    );

`ifdef ARB_B2B_GRANT_EN
    logic                b2b_found;
    logic [ID_WIDTH-1:0] b2b_idx;

    // The releasing owner is masked so it cannot immediately re-win.
    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_b2b_pick (
        .req       (req_valid),
        .start_ptr (next_ptr),
        .excl_mask (owner_onehot),
        .found     (b2b_found),
        .idx       (b2b_idx)
    );
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            StIdle: begin
                if (idle_found) begin
                    state_d     = StGrant;
                    grant_id_d  = idle_idx;
                    burst_cnt_d = '0;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
`ifdef ARB_B2B_GRANT_EN
                    if (b2b_found) begin
                        grant_id_d = b2b_idx;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = in_grant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed bench for fifo_write_arbiter. Each requester is a small beat queue;
// expected FIFO writes are queued as stimulus is issued and compared on every
// fifo_we. Inputs change 1 time unit after the rising edge, outputs are
// sampled at the falling edge or 1 unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned MAX_BURST  = 4;
    localparam int unsigned ID_WIDTH   = 2;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_we;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .ID_WIDTH   (ID_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_we   (fifo_we),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester beat storage: {last, data}.
    logic [8:0]         mem [NUM_REQ][64];
    int                 head [NUM_REQ];
    int                 tail [NUM_REQ];
    logic [NUM_REQ-1:0] en;
    logic [NUM_REQ-1:0] fire;
    logic [7:0]         exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic refresh();
        logic [8:0] b;
        for (int i = 0; i < NUM_REQ; i++) begin
            b = mem[i][head[i]];
            req_valid[i] = en[i] && (head[i] != tail[i]);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = b[7:0];
            req_last[i] = b[8] && req_valid[i];
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        en   = '1;
        fire = '0;
        exp_q.delete();
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input logic last);
        mem[r][tail[r]] = {last, d};
        tail[r]++;
    endtask

    task automatic expect_write(input logic [7:0] d);
        exp_q.push_back(d);
    endtask

    // Advance one clock: retire beats accepted at this edge, present the next.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire[i]) head[i]++;
        end
        refresh();
    endtask

    task automatic wait_we();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!fifo_we && n < 20);
        if (!fifo_we) check("wait_we_timeout", 32'(fifo_we), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 200) begin
            pending = busy || (exp_q.size() != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (en[i] && head[i] != tail[i]) pending = 1'b1;
            end
            if (pending) begin
                step();
                n++;
            end
        end
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        clear_all();
        refresh();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_fifo_we", 32'(fifo_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rst_n) begin
            fire = req_valid & req_ready;
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            check("we_matches_handshake", 32'(fifo_we), 32'(|fire));
            if (fifo_we) begin
                if (exp_q.size() == 0) begin
                    check("write_with_empty_scoreboard", 32'(fifo_we), 32'd0);
                end else begin
                    check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        do_reset();

        // Single requester, three beats, last on the third.
        push_beat(2, 8'hA1, 1'b0); expect_write(8'hA1);
        push_beat(2, 8'hA2, 1'b0); expect_write(8'hA2);
        push_beat(2, 8'hA3, 1'b1); expect_write(8'hA3);
        refresh();
        check("t1_idle_on_valid", 32'(busy), 32'd0);
        step();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_grant_id", 32'(grant_id), 32'd2);
        check("t1_we_beat1", 32'(fifo_we), 32'd1);
        step();
        check("t1_we_beat2", 32'(fifo_we), 32'd1);
        step();
        check("t1_we_beat3", 32'(fifo_we), 32'd1);
        step();
        check("t1_idle_after_last", 32'(busy), 32'd0);
        // rr_ptr now 3: with 0 and 3 both valid, 3 wins.
        push_beat(0, 8'hB0, 1'b1);
        push_beat(3, 8'hB3, 1'b1);
        expect_write(8'hB3);
        expect_write(8'hB0);
        refresh();
        step();
        check("t1_rr_ptr_3", 32'(grant_id), 32'd3);
        wait_drain();

        // Burst cap: six beats without last.
        for (int k = 0; k < 6; k++) begin
            push_beat(0, 8'(8'hC0 + k), 1'b0);
            expect_write(8'(8'hC0 + k));
        end
        refresh();
        step();
        check("t2_grant_id", 32'(grant_id), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("t2_we_in_burst", 32'(fifo_we), 32'd1);
            step();
        end
        check("t2_release_at_cap", 32'(busy), 32'd0);
        step();
        check("t2_regrant", 32'(busy), 32'd1);
        check("t2_regrant_we", 32'(fifo_we), 32'd1);
        wait_drain();

        // Round-robin fairness with 1-beat bursts.
        do_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                push_beat(i, 8'(8'h40 + i * 16 + n), 1'b1);
                expect_write(8'(8'h40 + i * 16 + n));
            end
        end
        refresh();
        for (int k = 0; k < 8; k++) begin
            wait_we();
            check("t3_rr_grant", 32'(grant_id), 32'(k % NUM_REQ));
        end
        wait_drain();

        // Backpressure mid-burst, then burst cap must still count correctly.
        for (int k = 0; k < 6; k++) begin
            push_beat(1, 8'(8'hE0 + k), 1'b0);
            expect_write(8'(8'hE0 + k));
        end
        refresh();
        step();
        check("t4_grant_id", 32'(grant_id), 32'd1);
        step();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_ready_low_full", 32'(req_ready), 32'd0);
            check("t4_we_low_full", 32'(fifo_we), 32'd0);
            check("t4_busy_held_full", 32'(busy), 32'd1);
            step();
        end
        fifo_full = 1'b0;
        #1;
        check("t4_we_at_deassert", 32'(fifo_we), 32'd1);
        check("t4_data_at_deassert", 32'(fifo_data), 32'hE1);
        step();
        check("t4_we_beat3", 32'(fifo_we), 32'd1);
        step();
        check("t4_we_beat4", 32'(fifo_we), 32'd1);
        step();
        check("t4_release_at_cap", 32'(busy), 32'd0);
        wait_drain();

        // Owner drops valid after one of three beats.
        push_beat(0, 8'hF0, 1'b0); expect_write(8'hF0);
        push_beat(0, 8'hF1, 1'b0);
        push_beat(0, 8'hF2, 1'b1);
        refresh();
        step();
        check("t5_grant_id", 32'(grant_id), 32'd0);
        push_beat(3, 8'h3C, 1'b1); expect_write(8'h3C);
        expect_write(8'hF1);
        expect_write(8'hF2);
        refresh();
        step();
        en[0] = 1'b0;
        refresh();
        check("t5_busy_before_drop_edge", 32'(busy), 32'd1);
        step();
`ifdef ARB_B2B_GRANT_EN
        check("t5_b2b_busy", 32'(busy), 32'd1);
        check("t5_b2b_next_grant", 32'(grant_id), 32'd3);
`else
        check("t5_release_on_drop", 32'(busy), 32'd0);
        step();
        check("t5_next_grant", 32'(grant_id), 32'd3);
`endif
        en[0] = 1'b1;
        refresh();
        wait_drain();

        // Asynchronous reset in the middle of a burst.
        push_beat(2, 8'h70, 1'b0); expect_write(8'h70);
        push_beat(2, 8'h71, 1'b0); expect_write(8'h71);
        push_beat(2, 8'h72, 1'b1); expect_write(8'h72);
        refresh();
        step();
        step();
        #2;
        check("t6_busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_ready", 32'(req_ready), 32'd0);
        check("t6_async_we", 32'(fifo_we), 32'd0);
        clear_all();
        refresh();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_beat(0, 8'h90, 1'b1); expect_write(8'h90);
        push_beat(3, 8'h93, 1'b1); expect_write(8'h93);
        refresh();
        step();
        check("t6_first_grant_lowest", 32'(grant_id), 32'd0);
        wait_drain();

        // Requesters 1 and 3: back-to-back hand-over or an IDLE gap.
        do_reset();
        push_beat(1, 8'hB1, 1'b1); expect_write(8'hB1);
        push_beat(3, 8'hB3, 1'b1); expect_write(8'hB3);
        refresh();
        step();
        check("t7_first_grant", 32'(grant_id), 32'd1);
        step();
`ifdef ARB_B2B_GRANT_EN
        check("t7_b2b_busy_held", 32'(busy), 32'd1);
        check("t7_b2b_grant", 32'(grant_id), 32'd3);
`else
        check("t7_idle_gap", 32'(busy), 32'd0);
        step();
        check("t7_second_grant", 32'(grant_id), 32'd3);
`endif
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
